// File: rtl/pc_fetch.sv
// Instruction fetch unit: FETCH/EXEC/HALT sequencer owning the program counter.
// Optional feature macro PC_HALT_ON_WRAP_EN: halt instead of wrapping on a sequential PC overflow.
module pc_fetch #(
    parameter int unsigned PSIZE  = 6,
    parameter int unsigned IWIDTH = 16
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              PCincr,
    input  logic              PCabsbranch,
    input  logic              PCrelbranch,
    input  logic [PSIZE-1:0]  Branchaddr,
    input  logic              stall,
    output logic              imem_req,
    output logic [PSIZE-1:0]  imem_addr,
    input  logic              imem_ack,
    input  logic [IWIDTH-1:0] imem_rdata,
    output logic [IWIDTH-1:0] instr,
    output logic              instr_valid,
    output logic [PSIZE-1:0]  pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state;
    logic [PSIZE-1:0] pc_nxt_c;

    // Next PC: absolute beats relative, either branch masks the increment.
    always_comb begin
        pc_nxt_c = pc;
        if (PCabsbranch) begin
            pc_nxt_c = Branchaddr;
        end else if (PCrelbranch) begin
            pc_nxt_c = PSIZE'(pc + Branchaddr);
        end else if (PCincr) begin
            pc_nxt_c = PSIZE'(pc + PSIZE'(1));
        end
    end

    assign imem_addr = pc;

`ifdef PC_HALT_ON_WRAP_EN
    logic wrap_c;
    assign wrap_c = PCincr & ~PCabsbranch & ~PCrelbranch & (pc == {PSIZE{1'b1}});
`else
    assign halted = 1'b0;
`endif

    // imem_req stays low for the first cycle after reset so an ack on that edge is never latched.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state       <= FETCH;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
`ifdef PC_HALT_ON_WRAP_EN
            halted      <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
`ifdef PC_HALT_ON_WRAP_EN
                        if (wrap_c) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            pc       <= pc_nxt_c;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
`else
                        pc       <= pc_nxt_c;
                        imem_req <= 1'b1;
                        state    <= FETCH;
`endif
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed scoreboard bench for pc_fetch; expected halt behaviour follows PC_HALT_ON_WRAP_EN.
module tb_pc_fetch;

    localparam int unsigned PSIZE  = 6;
    localparam int unsigned IWIDTH = 16;

    logic              clk = 1'b0;
    logic              nReset;
    logic              PCincr, PCabsbranch, PCrelbranch, stall;
    logic [PSIZE-1:0]  Branchaddr;
    logic              imem_req;
    logic [PSIZE-1:0]  imem_addr;
    logic              imem_ack;
    logic [IWIDTH-1:0] imem_rdata;
    logic [IWIDTH-1:0] instr;
    logic              instr_valid;
    logic [PSIZE-1:0]  pc;
    logic              halted;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [PSIZE-1:0]  pc;
        logic [IWIDTH-1:0] instr;
    } exp_t;
    exp_t sb[$];

    logic [PSIZE-1:0] model_pc;

    pc_fetch #(.PSIZE(PSIZE), .IWIDTH(IWIDTH)) dut (
        .clk(clk), .nReset(nReset),
        .PCincr(PCincr), .PCabsbranch(PCabsbranch), .PCrelbranch(PCrelbranch),
        .Branchaddr(Branchaddr), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_wait", 32'(imem_req), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pc"},    32'(pc),          32'd0);
        chk({tag, "_instr"}, 32'(instr),       32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_req"},   32'(imem_req),    32'd0);
        chk({tag, "_halt"},  32'(halted),      32'd0);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"},    32'(pc),    32'(e.pc));
            chk({tag, "_instr"}, 32'(instr), 32'(e.instr));
        end
    endtask

    // One fetch+execute; hold = cycles ack withheld, nstall = stalled EXEC edges.
    task automatic do_instr(input logic [IWIDTH-1:0] word, input logic incr, input logic abs,
                            input logic rel, input logic [PSIZE-1:0] baddr,
                            input int hold, input int nstall);
        logic [PSIZE-1:0] nxt;
        logic             exp_halt;
        wait_req();
        for (int i = 0; i < hold; i++) begin
            chk("hold_req",   32'(imem_req),    32'd1);
            chk("hold_addr",  32'(imem_addr),   32'(model_pc));
            chk("hold_valid", 32'(instr_valid), 32'd0);
            tick();
        end
        chk("fetch_addr", 32'(imem_addr), 32'(model_pc));
        imem_ack = 1'b1; imem_rdata = word;
        PCincr = incr; PCabsbranch = abs; PCrelbranch = rel; Branchaddr = baddr;
        sb.push_back('{model_pc, word});
        tick();
        imem_rdata = ~word;
        stall = (nstall > 0);
        chk("exec_valid", 32'(instr_valid), 32'd1);
        chk("exec_req",   32'(imem_req),    32'd0);
        pop_check("exec");
        for (int i = 0; i < nstall; i++) begin
            tick();
            chk("stall_pc",    32'(pc),          32'(model_pc));
            chk("stall_instr", 32'(instr),       32'(word));
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        if (abs)       nxt = baddr;
        else if (rel)  nxt = PSIZE'(model_pc + baddr);
        else if (incr) nxt = PSIZE'(model_pc + PSIZE'(1));
        else           nxt = model_pc;
`ifdef PC_HALT_ON_WRAP_EN
        exp_halt = incr && !abs && !rel && (model_pc == {PSIZE{1'b1}});
`else
        exp_halt = 1'b0;
`endif
        tick();
        imem_ack = 1'b0;
        PCincr = 1'b0; PCabsbranch = 1'b0; PCrelbranch = 1'b0; Branchaddr = '0;
        chk("after_valid", 32'(instr_valid), 32'd0);
        chk("after_instr", 32'(instr),       32'(word));
        if (exp_halt) begin
            chk("halt_flag", 32'(halted),   32'd1);
            chk("halt_pc",   32'(pc),       32'(model_pc));
            chk("halt_req",  32'(imem_req), 32'd0);
        end else begin
            model_pc = nxt;
            chk("next_pc",   32'(pc),       32'(model_pc));
            chk("next_req",  32'(imem_req), 32'd1);
            chk("next_halt", 32'(halted),   32'd0);
        end
    endtask

    initial begin
        nReset = 1'b0;
        PCincr = 1'b0; PCabsbranch = 1'b0; PCrelbranch = 1'b0; stall = 1'b0;
        Branchaddr = '0; imem_ack = 1'b0; imem_rdata = '0;
        model_pc = '0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        nReset = 1'b1;
        tick();
        chk("req_after_reset", 32'(imem_req), 32'd1);

        // Sequential issue 0,1,2,3
        do_instr(16'h0401, 1'b1, 1'b0, 1'b0, 6'h00, 0, 0);
        do_instr(16'h0802, 1'b1, 1'b0, 1'b0, 6'h00, 0, 0);
        do_instr(16'h0C03, 1'b1, 1'b0, 1'b0, 6'h00, 0, 0);
        // Ack withheld for five cycles
        do_instr(16'h1004, 1'b1, 1'b0, 1'b0, 6'h00, 5, 0);
        // Branch priority and relative wrap
        do_instr(16'h1405, 1'b0, 1'b1, 1'b0, 6'h0A, 0, 0);
        do_instr(16'h1806, 1'b1, 1'b1, 1'b1, 6'h03, 0, 0);
        do_instr(16'h1C07, 1'b1, 1'b0, 1'b1, 6'h3F, 0, 0);
        do_instr(16'h2008, 1'b0, 1'b0, 1'b1, 6'h3E, 0, 0);
        // No control: pc holds
        do_instr(16'h2409, 1'b0, 1'b0, 1'b0, 6'h15, 0, 0);
        // Stall three EXEC edges
        do_instr(16'h280A, 1'b1, 1'b0, 1'b0, 6'h00, 0, 3);
        // pc=1 with offset -2 wraps to 63, then sequential overflow
        do_instr(16'h2C0B, 1'b0, 1'b0, 1'b1, 6'h3E, 0, 0);
        do_instr(16'h300C, 1'b1, 1'b0, 1'b0, 6'h00, 0, 0);

`ifdef PC_HALT_ON_WRAP_EN
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_stay",  32'(halted),      32'd1);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_pc",    32'(pc),          32'h3F);
        end
        imem_ack = 1'b0;
        #2 nReset = 1'b0;
        #1 check_reset_vals("halt_reset");
        @(negedge clk);
        nReset = 1'b1;
        model_pc = '0;
`endif

        // Move pc off zero, then reset mid-EXEC between edges
        do_instr(16'h340D, 1'b0, 1'b1, 1'b0, 6'h05, 0, 0);
        wait_req();
        imem_ack = 1'b1; imem_rdata = 16'h380E;
        sb.push_back('{model_pc, 16'h380E});
        tick();
        imem_rdata = 16'hBEEF;
        chk("pre_reset_valid", 32'(instr_valid), 32'd1);
        pop_check("pre_reset");
        #2 nReset = 1'b0;
        #1 check_reset_vals("async_reset");
        model_pc = '0;
        // Ack coincident with the release edge must not be latched
        @(posedge clk);
        #1 nReset = 1'b1;
        imem_rdata = 16'hDEAD;
        tick();
        chk("release_instr", 32'(instr),       32'd0);
        chk("release_req",   32'(imem_req),    32'd1);
        chk("release_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b0;
        do_instr(16'h3C0F, 1'b1, 1'b0, 1'b0, 6'h00, 0, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
